// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALU function codes, opcodes and the
// decoded-instruction bundle handed from the decoder to the issue stage.
package mips_pkg;

  localparam int P_XLEN  = 32;
  localparam int P_RF_AW = 5;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_LUI   = 6'b111100;
  localparam logic [5:0] F_ROTR  = 6'b111110;
  localparam logic [5:0] F_ROTRV = 6'b111111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef struct packed {
    logic [5:0]         control;
    logic [P_XLEN-1:0]  op1;
    logic [P_XLEN-1:0]  op2;
    logic [P_RF_AW-1:0] dest;
    logic               illegal;
    logic               ovf_chk;
  } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-unit bus: upstream instruction handshake, ALU drive/return, retire handshake.
interface alu_issue_if
  import mips_pkg::*;
#(
  parameter int XLEN  = P_XLEN,
  parameter int RF_AW = P_RF_AW
) ();
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [XLEN-1:0]  i_rs_val;
  logic [XLEN-1:0]  i_rt_val;
  logic             i_flush;
  logic [XLEN-1:0]  o_alu_op1;
  logic [XLEN-1:0]  o_alu_op2;
  logic [5:0]       o_alu_control;
  logic [XLEN-1:0]  i_alu_result;
  logic             i_alu_overflow;
  logic             i_alu_zf;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_result;
  logic [RF_AW-1:0] o_dest;
  logic             o_wen;
  logic             o_ovf;
  logic             o_zf;
  logic             o_illegal;

  modport slave (
    input  i_valid, i_instr, i_rs_val, i_rt_val, i_flush,
           i_alu_result, i_alu_overflow, i_alu_zf, i_ready,
    output o_ready, o_alu_op1, o_alu_op2, o_alu_control,
           o_valid, o_result, o_dest, o_wen, o_ovf, o_zf, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_rs_val, i_rt_val, i_flush,
           i_alu_result, i_alu_overflow, i_alu_zf, i_ready,
    input  o_ready, o_alu_op1, o_alu_op2, o_alu_control,
           o_valid, o_result, o_dest, o_wen, o_ovf, o_zf, o_illegal
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational MIPS decoder: instruction word plus rs/rt values into an ALU
// function code, operand pair, destination and illegal/overflow-check flags.
module alu_issue_dec
  import mips_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [P_XLEN-1:0] rs_val,
  input  logic [P_XLEN-1:0] rt_val,
  output dec_t              dec
);
  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic        unused_rs_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign imm    = instr[15:0];
  assign unused_rs_bits = ^instr[25:22];

  always_comb begin
    dec         = '0;
    dec.op1     = rs_val;
    dec.op2     = rt_val;
    dec.dest    = rt;
    dec.control = F_SLL;
    unique case (opcode)
      OP_RTYPE: begin
        dec.dest = rd;
        case (funct)
          F_SLL, F_SRA: begin
            dec.control = funct;
            dec.op1     = {{(P_XLEN-5){1'b0}}, shamt};
          end
          // bit 21 (rs field) selects the rotate form of SRL
          F_SRL: begin
            dec.control = instr[21] ? F_ROTR : F_SRL;
            dec.op1     = {{(P_XLEN-5){1'b0}}, shamt};
          end
          F_SRLV:                          dec.control = instr[6] ? F_ROTRV : F_SRLV;
          F_ADD, F_SUB: begin
            dec.control = funct;
            dec.ovf_chk = 1'b1;
          end
          F_SLLV, F_SRAV, F_ADDU, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU:     dec.control = funct;
          default:                         dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.control = F_ADD;
        dec.op2     = {{(P_XLEN-16){imm[15]}}, imm};
        dec.ovf_chk = 1'b1;
      end
      OP_ADDIU: begin dec.control = F_ADDU; dec.op2 = {{(P_XLEN-16){imm[15]}}, imm}; end
      OP_SLTI:  begin dec.control = F_SLT;  dec.op2 = {{(P_XLEN-16){imm[15]}}, imm}; end
      OP_SLTIU: begin dec.control = F_SLTU; dec.op2 = {{(P_XLEN-16){imm[15]}}, imm}; end
      OP_ANDI:  begin dec.control = F_AND;  dec.op2 = {{(P_XLEN-16){1'b0}}, imm}; end
      OP_ORI:   begin dec.control = F_OR;   dec.op2 = {{(P_XLEN-16){1'b0}}, imm}; end
      OP_XORI:  begin dec.control = F_XOR;  dec.op2 = {{(P_XLEN-16){1'b0}}, imm}; end
      OP_LUI:   begin dec.control = F_LUI;  dec.op2 = {{(P_XLEN-16){1'b0}}, imm}; end
      default:  dec.illegal = 1'b1;
    endcase
    // illegal entries drive a harmless all-zero ALU op
    if (dec.illegal) begin
      dec.control = 6'b000000;
      dec.op1     = '0;
      dec.op2     = '0;
      dec.ovf_chk = 1'b0;
    end
  end
endmodule

// File: rtl/alu_issue.sv
// Two-stage execute issue/retire: E1 holds the decoded op driving the external
// combinational ALU, E2 captures its result for retire under valid/ready.
module alu_issue
  import mips_pkg::*;
#(
  parameter int XLEN  = P_XLEN,
  parameter int RF_AW = P_RF_AW
) (
  input logic       i_clk,
  input logic       i_rst,
  alu_issue_if.slave bus
);
  dec_t dec;

  alu_issue_dec u_dec (
    .instr  (bus.i_instr),
    .rs_val (bus.i_rs_val),
    .rt_val (bus.i_rt_val),
    .dec    (dec)
  );

  logic             e1_vld_q, e1_vld_d;
  dec_t             e1_q, e1_d;
  logic             e2_vld_q, e2_vld_d;
  logic [XLEN-1:0]  e2_res_q, e2_res_d;
  logic [RF_AW-1:0] e2_dest_q, e2_dest_d;
  logic             e2_wen_q, e2_wen_d;
  logic             e2_ovf_q, e2_ovf_d;
  logic             e2_zf_q, e2_zf_d;
  logic             e2_ill_q, e2_ill_d;
  logic             e2_load, ready, accept, ovf;

  always_comb begin
    e2_load = !e2_vld_q || bus.i_ready;
    ready   = !e1_vld_q || e2_load;
    accept  = bus.i_valid && ready;
    ovf     = bus.i_alu_overflow && e1_q.ovf_chk;

    e1_vld_d  = e1_vld_q;
    e1_d      = e1_q;
    e2_vld_d  = e2_vld_q;
    e2_res_d  = e2_res_q;
    e2_dest_d = e2_dest_q;
    e2_wen_d  = e2_wen_q;
    e2_ovf_d  = e2_ovf_q;
    e2_zf_d   = e2_zf_q;
    e2_ill_d  = e2_ill_q;

    if (bus.i_flush) begin
      e1_vld_d = 1'b0;
    end else if (accept) begin
      e1_vld_d = 1'b1;
      e1_d     = dec;
    end else if (e2_load) begin
      e1_vld_d = 1'b0;
    end

    if (bus.i_flush) begin
      e2_vld_d = 1'b0;
      e2_wen_d = 1'b0;
    end else if (e2_load) begin
      e2_vld_d = e1_vld_q;
      e2_wen_d = 1'b0;
      e2_ovf_d = 1'b0;
      e2_zf_d  = 1'b0;
      e2_ill_d = 1'b0;
      if (e1_vld_q) begin
        e2_res_d  = e1_q.illegal ? '0 : bus.i_alu_result;
        e2_dest_d = e1_q.dest;
        e2_ovf_d  = ovf;
        e2_zf_d   = bus.i_alu_zf;
        e2_ill_d  = e1_q.illegal;
        e2_wen_d  = !e1_q.illegal && !ovf && (e1_q.dest != '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e1_vld_q  <= 1'b0;
      e1_q      <= '0;
      e2_vld_q  <= 1'b0;
      e2_res_q  <= '0;
      e2_dest_q <= '0;
      e2_wen_q  <= 1'b0;
      e2_ovf_q  <= 1'b0;
      e2_zf_q   <= 1'b0;
      e2_ill_q  <= 1'b0;
    end else begin
      e1_vld_q  <= e1_vld_d;
      e1_q      <= e1_d;
      e2_vld_q  <= e2_vld_d;
      e2_res_q  <= e2_res_d;
      e2_dest_q <= e2_dest_d;
      e2_wen_q  <= e2_wen_d;
      e2_ovf_q  <= e2_ovf_d;
      e2_zf_q   <= e2_zf_d;
      e2_ill_q  <= e2_ill_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_alu_op1     = e1_q.op1;
  assign bus.o_alu_op2     = e1_q.op2;
  assign bus.o_alu_control = e1_q.control;
  assign bus.o_valid       = e2_vld_q;
  assign bus.o_result      = e2_res_q;
  assign bus.o_dest        = e2_dest_q;
  assign bus.o_wen         = e2_wen_q;
  assign bus.o_ovf         = e2_ovf_q;
  assign bus.o_zf          = e2_zf_q;
  assign bus.o_illegal     = e2_ill_q;
endmodule
